// File: rtl/simon_pkg.sv
// Shared types and sizing for the memory-game sequencer.
package simon_pkg;
  localparam int SYM_W  = 3;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW,
    GAP,
    WAIT_IN,
    WIN,
    LOSE
  } state_t;
endpackage

// File: rtl/simon_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) feeding new game symbols.
module simon_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEED;
    else     state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
  end

endmodule

// File: rtl/simon_seq_ctrl.sv
// Memory-game sequencer: appends a random symbol each round, plays the
// sequence back to the display, then checks the player's presses against it.
module simon_seq_ctrl
  import simon_pkg::*;
#(
  parameter int         DEPTH       = simon_pkg::DEPTH,
  parameter int         SYM_W       = simon_pkg::SYM_W,
  parameter int         SHOW_CYCLES = 8,
  parameter int         GAP_CYCLES  = 4,
  parameter int         TIMEOUT     = 1024,
  parameter logic [7:0] LFSR_SEED   = 8'hA5,
  localparam int        ADDR_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              btn_valid,
  input  logic [SYM_W-1:0]  btn_sym,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [SYM_W-1:0]  rf_wr_data,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [SYM_W-1:0]  rf_rd_data,
  output logic              show_valid,
  output logic [SYM_W-1:0]  show_sym,
  output logic              input_ready,
  output logic [ADDR_W:0]   level,
  output logic              win,
  output logic              lose
);

  localparam int CNT_MAX_SG = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX    = (TIMEOUT > CNT_MAX_SG) ? TIMEOUT : CNT_MAX_SG;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   LVL_FULL  = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        lfsr;
  logic              lfsr_unused;
  logic [ADDR_W:0]   level_m1;
  logic              at_last;

  simon_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  assign lfsr_unused = ^lfsr[7:SYM_W];
  assign level_m1    = level_q - LVL_ONE;
  assign at_last     = ({1'b0, idx_q} == level_m1);
  assign level       = level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rf_we       = 1'b0;
    rf_wr_addr  = '0;
    rf_wr_data  = '0;
    rf_rd_addr  = '0;
    show_valid  = 1'b0;
    show_sym    = '0;
    input_ready = 1'b0;
    win         = 1'b0;
    lose        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          level_d = '0;
          state_d = GEN;
        end
      end
      GEN: begin
        // The write lands on this edge, so entry level-1 is valid for SHOW.
        rf_we      = 1'b1;
        rf_wr_addr = level_q[ADDR_W-1:0];
        rf_wr_data = lfsr[SYM_W-1:0];
        level_d    = level_q + LVL_ONE;
        idx_d      = '0;
        cnt_d      = '0;
        state_d    = SHOW;
      end
      SHOW: begin
        rf_rd_addr = idx_q;
        show_valid = 1'b1;
        show_sym   = rf_rd_data;
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (at_last) begin
            idx_d   = '0;
            state_d = WAIT_IN;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = SHOW;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_IN: begin
        input_ready = 1'b1;
        rf_rd_addr  = idx_q;
        cnt_d       = cnt_q + CNT_ONE;
        if (btn_valid) begin
          if (btn_sym == rf_rd_data) begin
            cnt_d = '0;
            if (at_last) state_d = (level_q == LVL_FULL) ? WIN : GEN;
            else         idx_d   = idx_q + IDX_ONE;
          end else begin
            state_d = LOSE;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d = LOSE;
        end
      end
      WIN, LOSE: begin
        win  = (state_q == WIN);
        lose = (state_q == LOSE);
        if (start) begin
          level_d = '0;
          state_d = GEN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Randomised bench for simon_seq_ctrl with an attached reg-file model and a
// queue-based model of the game sequence.
module tb_simon_seq_ctrl;

  localparam int SHOW_N  = 8;
  localparam int GAP_N   = 4;
  localparam int TO_N    = 16;
  localparam int DEPTH_N = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       btn_valid;
  logic [2:0] btn_sym;
  logic       rf_we;
  logic [3:0] rf_wr_addr;
  logic [2:0] rf_wr_data;
  logic [3:0] rf_rd_addr;
  logic [2:0] rf_rd_data;
  logic       show_valid;
  logic [2:0] show_sym;
  logic       input_ready;
  logic [4:0] level;
  logic       win;
  logic       lose;

  logic [2:0] mem [16];
  logic [7:0] m_lfsr;
  bit   [2:0] seq [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  simon_seq_ctrl #(
    .SHOW_CYCLES (SHOW_N),
    .GAP_CYCLES  (GAP_N),
    .TIMEOUT     (TO_N),
    .LFSR_SEED   (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .btn_valid   (btn_valid),
    .btn_sym     (btn_sym),
    .rf_we       (rf_we),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_data  (rf_rd_data),
    .show_valid  (show_valid),
    .show_sym    (show_sym),
    .input_ready (input_ready),
    .level       (level),
    .win         (win),
    .lose        (lose)
  );

  // Register file: synchronous write, combinational read.
  always @(posedge clk) if (rf_we) mem[rf_wr_addr] <= rf_wr_data;
  assign rf_rd_data = mem[rf_rd_addr];

  // Reference LFSR: x^8+x^6+x^5+x^4 Fibonacci, stepping every cycle from the seed.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    seq.delete();
  endtask

  // Entered with the DUT in GEN for round L; returns at the first WAIT_IN cycle.
  task automatic check_round(input int L, input bit noise);
    checks++;
    if (rf_we !== 1'b1 || rf_wr_addr !== 4'(L - 1))
      begin errors++; $display("FAIL gen_write L=%0d: we=%b addr=%0d want 1/%0d", L, rf_we, rf_wr_addr, L - 1); end
    checks++;
    if (rf_wr_data !== m_lfsr[2:0])
      begin errors++; $display("FAIL gen_data L=%0d: got %0d want %0d", L, rf_wr_data, m_lfsr[2:0]); end
    seq.push_back(m_lfsr[2:0]);
    if (noise) begin btn_valid = 1'($urandom); btn_sym = 3'($urandom); start = 1'($urandom); end
    tick();
    checks++;
    if (level !== 5'(L))
      begin errors++; $display("FAIL level_after_gen: got %0d want %0d", level, L); end
    for (int i = 0; i < L; i++) begin
      for (int c = 0; c < SHOW_N; c++) begin
        checks++;
        if (show_valid !== 1'b1 || show_sym !== seq[i] || input_ready !== 1'b0)
          begin errors++; $display("FAIL show L=%0d i=%0d c=%0d: valid=%b sym=%0d rdy=%b want 1/%0d/0", L, i, c, show_valid, show_sym, input_ready, seq[i]); end
        if (noise) begin btn_valid = 1'($urandom); btn_sym = 3'($urandom); start = 1'($urandom); end
        tick();
      end
      for (int c = 0; c < GAP_N; c++) begin
        checks++;
        if (show_valid !== 1'b0 || show_sym !== 3'd0 || input_ready !== 1'b0)
          begin errors++; $display("FAIL gap L=%0d i=%0d c=%0d: valid=%b sym=%0d rdy=%b want 0/0/0", L, i, c, show_valid, show_sym, input_ready); end
        if (noise) begin btn_valid = 1'($urandom); btn_sym = 3'($urandom); start = 1'($urandom); end
        tick();
      end
    end
    btn_valid = 1'b0;
    start     = 1'b0;
    checks++;
    if (input_ready !== 1'b1 || level !== 5'(L))
      begin errors++; $display("FAIL wait_entry L=%0d: rdy=%b level=%0d want 1/%0d", L, input_ready, level, L); end
  endtask

  task automatic answer_round(input int L);
    for (int i = 0; i < L; i++) begin
      checks++;
      if (input_ready !== 1'b1)
        begin errors++; $display("FAIL answer_ready L=%0d i=%0d: got %b want 1", L, i, input_ready); end
      btn_valid = 1'b1;
      btn_sym   = seq[i];
      tick();
      btn_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; btn_valid = 1'b0; btn_sym = 3'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({rf_we, rf_wr_addr, rf_wr_data, rf_rd_addr, show_valid, show_sym, input_ready, level, win, lose} !== 24'd0)
      begin errors++; $display("FAIL reset_idle: outputs not quiet, level=%0d", level); end
    do_start();
    tick(); tick(); tick();
    checks++;
    if (show_valid !== 1'b1)
      begin errors++; $display("FAIL pre_reset_show: valid=%b want 1", show_valid); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rf_we, rf_wr_addr, rf_wr_data, rf_rd_addr, show_valid, show_sym, input_ready, level, win, lose} !== 24'd0)
      begin errors++; $display("FAIL async_reset: show_valid=%b level=%0d want all 0", show_valid, level); end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (level !== 5'd0 || show_valid !== 1'b0 || rf_we !== 1'b0)
      begin errors++; $display("FAIL after_reset: level=%0d valid=%b we=%b want 0", level, show_valid, rf_we); end
  endtask

  task automatic test_first_round;
    do_start();
    check_round(1, 1'b0);
  endtask

  task automatic test_full_game;
    for (int L = 1; L <= DEPTH_N; L++) begin
      answer_round(L);
      if (L < DEPTH_N) check_round(L + 1, 1'b0);
    end
    checks++;
    if (win !== 1'b1 || lose !== 1'b0 || level !== 5'd16 || input_ready !== 1'b0)
      begin errors++; $display("FAIL win_state: win=%b lose=%b level=%0d rdy=%b want 1/0/16/0", win, lose, level, input_ready); end
    for (int c = 0; c < 20; c++) begin
      btn_valid = 1'($urandom); btn_sym = 3'($urandom);
      tick();
      checks++;
      if (rf_we !== 1'b0 || win !== 1'b1 || level !== 5'd16)
        begin errors++; $display("FAIL win_hold c=%0d: we=%b win=%b level=%0d want 0/1/16", c, rf_we, win, level); end
    end
    btn_valid = 1'b0;
  endtask

  task automatic test_wrong_press;
    do_start();
    check_round(1, 1'b0); answer_round(1);
    check_round(2, 1'b0); answer_round(2);
    check_round(3, 1'b0);
    for (int i = 0; i < 2; i++) begin
      btn_valid = 1'b1; btn_sym = seq[i];
      tick();
    end
    btn_sym = seq[2] ^ 3'(1 + $urandom_range(0, 6));
    tick();
    btn_valid = 1'b0;
    checks++;
    if (lose !== 1'b1 || level !== 5'd3 || input_ready !== 1'b0)
      begin errors++; $display("FAIL wrong_press: lose=%b level=%0d rdy=%b want 1/3/0", lose, level, input_ready); end
    for (int c = 0; c < 10; c++) begin
      btn_valid = 1'b1; btn_sym = 3'($urandom);
      tick();
      checks++;
      if (lose !== 1'b1 || level !== 5'd3 || rf_we !== 1'b0 || win !== 1'b0)
        begin errors++; $display("FAIL lose_hold c=%0d: lose=%b level=%0d we=%b", c, lose, level, rf_we); end
    end
    btn_valid = 1'b0;
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    do_start();
    check_round(1, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (lose === 1'b1) begin n = k; break; end
      checks++;
      if (input_ready !== 1'b1)
        begin errors++; $display("FAIL timeout_wait k=%0d: rdy=%b want 1", k, input_ready); end
    end
    checks++;
    if (n != TO_N)
      begin errors++; $display("FAIL timeout_cycles: lose after %0d cycles want %0d", n, TO_N); end
  endtask

  task automatic test_ignored;
    do_start();
    check_round(1, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (input_ready !== 1'b1 || rf_we !== 1'b0 || show_valid !== 1'b0 || level !== 5'd1)
      begin errors++; $display("FAIL start_in_wait: rdy=%b we=%b valid=%b level=%0d want 1/0/0/1", input_ready, rf_we, show_valid, level); end
    answer_round(1);
    check_round(2, 1'b1);
    btn_valid = 1'b1; btn_sym = seq[0] ^ 3'd5;
    tick();
    btn_valid = 1'b0;
    checks++;
    if (lose !== 1'b1 || level !== 5'd2)
      begin errors++; $display("FAIL lose_round2: lose=%b level=%0d want 1/2", lose, level); end
    start = 1'b1; btn_valid = 1'b1; btn_sym = 3'($urandom);
    tick();
    start = 1'b0; btn_valid = 1'b0;
    seq.delete();
    checks++;
    if (rf_we !== 1'b1 || lose !== 1'b0 || rf_wr_addr !== 4'd0)
      begin errors++; $display("FAIL start_beats_btn: we=%b lose=%b addr=%0d want 1/0/0", rf_we, lose, rf_wr_addr); end
    check_round(1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_full_game();
    test_wrong_press();
    test_timeout();
    test_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
